// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the 8-bit CPU control unit: opcodes, control-word layout,
// inactive control value and step-counter sizing.
package cpu_ctrl_pkg;

    localparam int OPCODE_WIDTH      = 4;
    localparam int NUM_STEPS_DEFAULT = 5;
    localparam int STEP_W            = $clog2(NUM_STEPS_DEFAULT);
    localparam int CTRL_W            = 16;

    typedef logic [OPCODE_WIDTH-1:0] opcode_t;
    typedef logic [STEP_W-1:0]       step_t;
    typedef logic [CTRL_W-1:0]       ctrl_word_t;
    typedef logic [3:0]              cw_idx_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } seq_state_e;

    localparam opcode_t OP_NOP = 4'h0;
    localparam opcode_t OP_LDA = 4'h1;
    localparam opcode_t OP_ADD = 4'h2;
    localparam opcode_t OP_SUB = 4'h3;
    localparam opcode_t OP_STA = 4'h4;
    localparam opcode_t OP_LDI = 4'h5;
    localparam opcode_t OP_JMP = 4'h6;
    localparam opcode_t OP_JC  = 4'h7;
    localparam opcode_t OP_JZ  = 4'h8;
    localparam opcode_t OP_OUT = 4'hE;
    localparam opcode_t OP_HLT = 4'hF;

    localparam cw_idx_t CW_HLT  = 4'd0;
    localparam cw_idx_t CW_MI   = 4'd1;
    localparam cw_idx_t CW_RI   = 4'd2;
    localparam cw_idx_t CW_RO   = 4'd3;
    localparam cw_idx_t CW_II   = 4'd4;
    localparam cw_idx_t CW_IO   = 4'd5;
    localparam cw_idx_t CW_AI   = 4'd6;
    localparam cw_idx_t CW_AO   = 4'd7;
    localparam cw_idx_t CW_BI   = 4'd8;
    localparam cw_idx_t CW_SU   = 4'd9;
    localparam cw_idx_t CW_EO_N = 4'd10;
    localparam cw_idx_t CW_FI_N = 4'd11;
    localparam cw_idx_t CW_OI   = 4'd12;
    localparam cw_idx_t CW_CE   = 4'd13;
    localparam cw_idx_t CW_CO   = 4'd14;
    localparam cw_idx_t CW_J    = 4'd15;

    localparam ctrl_word_t M_HLT  = 16'h0001 << CW_HLT;
    localparam ctrl_word_t M_MI   = 16'h0001 << CW_MI;
    localparam ctrl_word_t M_RI   = 16'h0001 << CW_RI;
    localparam ctrl_word_t M_RO   = 16'h0001 << CW_RO;
    localparam ctrl_word_t M_II   = 16'h0001 << CW_II;
    localparam ctrl_word_t M_IO   = 16'h0001 << CW_IO;
    localparam ctrl_word_t M_AI   = 16'h0001 << CW_AI;
    localparam ctrl_word_t M_AO   = 16'h0001 << CW_AO;
    localparam ctrl_word_t M_BI   = 16'h0001 << CW_BI;
    localparam ctrl_word_t M_SU   = 16'h0001 << CW_SU;
    localparam ctrl_word_t M_EO_N = 16'h0001 << CW_EO_N;
    localparam ctrl_word_t M_FI_N = 16'h0001 << CW_FI_N;
    localparam ctrl_word_t M_OI   = 16'h0001 << CW_OI;
    localparam ctrl_word_t M_CE   = 16'h0001 << CW_CE;
    localparam ctrl_word_t M_CO   = 16'h0001 << CW_CO;
    localparam ctrl_word_t M_J    = 16'h0001 << CW_J;

    // EO_n and FI_n idle high; everything else idles low.
    localparam ctrl_word_t CW_INACTIVE  = M_EO_N | M_FI_N;
    localparam ctrl_word_t CW_LOAD_MASK = M_MI | M_RI | M_II | M_AI | M_BI |
                                          M_OI | M_CE | M_J  | M_FI_N;

    // Masks name the controls to assert; XOR with the idle word handles polarity.
    function automatic ctrl_word_t cw_make(input ctrl_word_t asserted);
        return CW_INACTIVE ^ asserted;
    endfunction

    function automatic logic is_fetch_only(input opcode_t op);
        logic r;
        case (op)
            OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI,
            OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: r = 1'b0;
            default:                              r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle between the control sequencer (master) and the CPU datapath (slave):
// opcode/flags in, per-cycle control strobes and debug step out.
interface control_sequencer_if;
    import cpu_ctrl_pkg::*;

    opcode_t IR_OP;
    logic    CF;
    logic    ZF;
    logic    HLT;
    logic    MI;
    logic    RI;
    logic    RO;
    logic    II;
    logic    IO;
    logic    AI;
    logic    AO;
    logic    BI;
    logic    SU;
    logic    EO_n;
    logic    FI_n;
    logic    OI;
    logic    CE;
    logic    CO;
    logic    J;
    step_t   STEP_IDX;
    logic    INSTR_END;

    modport master (
        input  IR_OP, CF, ZF,
        output HLT, MI, RI, RO, II, IO, AI, AO, BI, SU, EO_n, FI_n, OI, CE, CO, J,
        output STEP_IDX, INSTR_END
    );

    modport slave (
        output IR_OP, CF, ZF,
        input  HLT, MI, RI, RO, II, IO, AI, AO, BI, SU, EO_n, FI_n, OI, CE, CO, J,
        input  STEP_IDX, INSTR_END
    );

endinterface

// File: rtl/control_rom.sv
// Combinational microcode: (opcode, T-state, CF, ZF) -> control word plus a flag
// marking the last active step of the instruction.
module control_rom
    import cpu_ctrl_pkg::*;
(
    input  opcode_t    i_opcode,
    input  step_t      i_step,
    input  logic       i_cf,
    input  logic       i_zf,
    output ctrl_word_t o_ctrl,
    output logic       o_last_step
);

    // Microcode lookup; fetch is shared in T0/T1, execute decodes the opcode.
    always_comb begin
        o_ctrl      = CW_INACTIVE;
        o_last_step = 1'b0;
        case (i_step)
            3'd0: o_ctrl = cw_make(M_CO | M_MI);
            3'd1: begin
                o_ctrl      = cw_make(M_RO | M_II | M_CE);
                o_last_step = is_fetch_only(i_opcode);
            end
            3'd2: begin
                case (i_opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: o_ctrl = cw_make(M_IO | M_MI);
                    OP_LDI: begin
                        o_ctrl      = cw_make(M_IO | M_AI);
                        o_last_step = 1'b1;
                    end
                    OP_JMP: begin
                        o_ctrl      = cw_make(M_IO | M_J);
                        o_last_step = 1'b1;
                    end
                    // Untaken conditional jumps still end here with an idle word.
                    OP_JC: begin
                        o_ctrl      = i_cf ? cw_make(M_IO | M_J) : CW_INACTIVE;
                        o_last_step = 1'b1;
                    end
                    OP_JZ: begin
                        o_ctrl      = i_zf ? cw_make(M_IO | M_J) : CW_INACTIVE;
                        o_last_step = 1'b1;
                    end
                    OP_OUT: begin
                        o_ctrl      = cw_make(M_AO | M_OI);
                        o_last_step = 1'b1;
                    end
                    OP_HLT: begin
                        o_ctrl      = cw_make(M_HLT);
                        o_last_step = 1'b1;
                    end
                    default: o_ctrl = CW_INACTIVE;
                endcase
            end
            3'd3: begin
                case (i_opcode)
                    OP_LDA: begin
                        o_ctrl      = cw_make(M_RO | M_AI);
                        o_last_step = 1'b1;
                    end
                    OP_ADD, OP_SUB: o_ctrl = cw_make(M_RO | M_BI);
                    OP_STA: begin
                        o_ctrl      = cw_make(M_AO | M_RI);
                        o_last_step = 1'b1;
                    end
                    default: o_ctrl = CW_INACTIVE;
                endcase
            end
            3'd4: begin
                case (i_opcode)
                    OP_ADD: begin
                        o_ctrl      = cw_make(M_EO_N | M_AI | M_FI_N);
                        o_last_step = 1'b1;
                    end
                    OP_SUB: begin
                        o_ctrl      = cw_make(M_EO_N | M_AI | M_FI_N | M_SU);
                        o_last_step = 1'b1;
                    end
                    default: o_ctrl = CW_INACTIVE;
                endcase
            end
            default: o_ctrl = CW_INACTIVE;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Microcoded control unit: RUN/HALT FSM, T-state counter and control-word gating.
// Optional feature macro CTRL_SINGLE_STEP_EN adds a STEP input for single-stepping.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W  = OPCODE_WIDTH,
    parameter int NUM_STEPS = NUM_STEPS_DEFAULT
)(
    input  logic CLK,
    input  logic CLR,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic STEP,
`endif
    control_sequencer_if.master bus
);

    localparam step_t LAST_STEP = step_t'(NUM_STEPS - 1);

    seq_state_e          r_state;
    seq_state_e          w_next_state;
    step_t               r_step;
    step_t               w_next_step;
    logic [OPCODE_W-1:0] w_op;
    ctrl_word_t          w_rom_cw;
    ctrl_word_t          w_cw_out;
    logic                w_rom_last;
    logic                w_adv;
    logic                w_instr_end;

    assign w_op = bus.IR_OP;

`ifdef CTRL_SINGLE_STEP_EN
    assign w_adv = STEP;
`else
    assign w_adv = 1'b1;
`endif

    control_rom u_rom (
        .i_opcode    (w_op),
        .i_step      (r_step),
        .i_cf        (bus.CF),
        .i_zf        (bus.ZF),
        .o_ctrl      (w_rom_cw),
        .o_last_step (w_rom_last)
    );

    // Next state and step; the last step of an instruction or T4 wraps to T0.
    always_comb begin
        w_next_state = r_state;
        w_next_step  = r_step;
        case (r_state)
            ST_RUN: begin
                if (w_adv) begin
                    if (w_rom_last || (r_step >= LAST_STEP)) begin
                        w_next_step = step_t'(0);
                    end else begin
                        w_next_step = r_step + step_t'(1);
                    end
                    if (w_rom_cw[CW_HLT]) begin
                        w_next_state = ST_HALT;
                    end else begin
                        w_next_state = ST_RUN;
                    end
                end else begin
                    w_next_state = ST_RUN;
                    w_next_step  = r_step;
                end
            end
            ST_HALT: begin
                w_next_state = ST_HALT;
                w_next_step  = step_t'(0);
            end
            default: begin
                w_next_state = ST_RUN;
                w_next_step  = step_t'(0);
            end
        endcase
    end

    // State and step registers with synchronous clear.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_state <= ST_RUN;
            r_step  <= step_t'(0);
        end else begin
            r_state <= w_next_state;
            r_step  <= w_next_step;
        end
    end

    // Output gating: idle under CLR, HLT only in HALT, loads masked while a step is held.
    always_comb begin
        w_cw_out    = CW_INACTIVE;
        w_instr_end = 1'b0;
        if (CLR) begin
            w_cw_out    = CW_INACTIVE;
            w_instr_end = 1'b0;
        end else if (r_state == ST_HALT) begin
            w_cw_out    = cw_make(M_HLT);
            w_instr_end = 1'b0;
        end else if (w_adv) begin
            w_cw_out    = w_rom_cw;
            w_instr_end = w_rom_last;
        end else begin
            w_cw_out    = (w_rom_cw & ~CW_LOAD_MASK) | (CW_INACTIVE & CW_LOAD_MASK);
            w_instr_end = w_rom_last;
        end
    end

    assign bus.HLT       = w_cw_out[CW_HLT];
    assign bus.MI        = w_cw_out[CW_MI];
    assign bus.RI        = w_cw_out[CW_RI];
    assign bus.RO        = w_cw_out[CW_RO];
    assign bus.II        = w_cw_out[CW_II];
    assign bus.IO        = w_cw_out[CW_IO];
    assign bus.AI        = w_cw_out[CW_AI];
    assign bus.AO        = w_cw_out[CW_AO];
    assign bus.BI        = w_cw_out[CW_BI];
    assign bus.SU        = w_cw_out[CW_SU];
    assign bus.EO_n      = w_cw_out[CW_EO_N];
    assign bus.FI_n      = w_cw_out[CW_FI_N];
    assign bus.OI        = w_cw_out[CW_OI];
    assign bus.CE        = w_cw_out[CW_CE];
    assign bus.CO        = w_cw_out[CW_CO];
    assign bus.J         = w_cw_out[CW_J];
    assign bus.STEP_IDX  = r_step;
    assign bus.INSTR_END = w_instr_end;

endmodule
